// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - shared ISA constants and instruction-memory state type
package cpu_isa_pkg;

  localparam int OPC_W = 5;
  localparam int OPR_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd2;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd3;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd4;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd5;
  localparam logic [OPC_W-1:0] OP_SETI = 5'd6;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd7;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'd8;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'd9;
  localparam logic [OPC_W-1:0] OP_HALT = 5'd26;

  // The all-zero word decodes as "add r0", which the pipeline treats as a bubble.
  localparam logic [OPC_W+OPR_W-1:0] HALT_WORD = {OP_HALT, 4'b0000};
  localparam logic [OPC_W+OPR_W-1:0] NOP_WORD  = {OP_ADD, 4'b0000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction storage, synchronous write, asynchronous read
module imem_array #(
  parameter int INST_W = 9,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; prog_len gating hides stale words.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - run-time loadable instruction memory with registered fetch port
module instr_mem_loadable
  import cpu_isa_pkg::*;
#(
  parameter int                INST_W = 9,
  parameter int                PC_W   = 16,
  parameter int                DEPTH  = 64,
  parameter logic [INST_W-1:0] FILL   = INST_W'(HALT_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc,
  input  logic              fetch_en,
  input  logic              stall,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [PC_W:0]     prog_len,
  output logic              load_err,
  output logic              running
);

  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W:0] DEPTH_LEN = (PC_W + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

  imem_state_t       state, state_nxt;
  logic [AW-1:0]     wptr;
  logic [PC_W:0]     wptr_inc;
  logic              beat;
  logic              at_end;
  logic              in_range;
  logic [INST_W-1:0] rdata;

  imem_array #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (beat),
    .waddr (wptr),
    .wdata (load_data),
    .raddr (pc[AW-1:0]),
    .rdata (rdata)
  );

  assign wptr_inc = (PC_W + 1)'(wptr) + (PC_W + 1)'(1);
  assign at_end   = (wptr == LAST_SLOT);
  // Full-width compare so a PC above DEPTH never aliases onto a low slot.
  assign in_range = ({1'b0, pc} < prog_len);
  assign running  = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // load_start outranks a same-cycle beat, so the beat is masked here.
  always_comb begin
    state_nxt  = state;
    load_ready = (state == LOAD);
    beat       = load_ready && load_valid && !load_start;
    if (load_start) begin
      state_nxt = LOAD;
    end else if (beat && (load_last || at_end)) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      prog_len <= '0;
      load_err <= 1'b0;
    end else if (load_start) begin
      wptr     <= '0;
      prog_len <= '0;
      load_err <= 1'b0;
    end else if (beat) begin
      wptr <= wptr + AW'(1);
      if (load_last) begin
        prog_len <= wptr_inc;
      end else if (at_end) begin
        prog_len <= DEPTH_LEN;
        load_err <= 1'b1;
      end
    end
  end

  // A load_start seen in RUN clears the fetch register on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_out   <= '0;
      inst_valid <= 1'b0;
    end else if ((state == RUN) && !load_start) begin
      if (!stall) begin
        if (fetch_en) begin
          inst_out   <= in_range ? rdata : FILL;
          inst_valid <= 1'b1;
        end else begin
          inst_out   <= INST_W'(NOP_WORD);
          inst_valid <= 1'b0;
        end
      end
    end else begin
      inst_out   <= '0;
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - directed self-checking bench for instr_mem_loadable
module tb_instr_mem_loadable;

  localparam logic [8:0] FILL_W = 9'b110100000;
  localparam logic [8:0] SETI_W = 9'b001100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        fetch_en;
  logic        stall;
  logic [8:0]  inst_out;
  logic        inst_valid;
  logic        load_start;
  logic        load_valid;
  logic [8:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic [16:0] prog_len;
  logic        load_err;
  logic        running;

  int total = 0;
  int bad   = 0;

  instr_mem_loadable dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .stall      (stall),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .prog_len   (prog_len),
    .load_err   (load_err),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_beat(input logic [8:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic do_fetch(input logic [15:0] a);
    fetch_en = 1'b1;
    pc       = a;
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({inst_valid, inst_out, load_ready, prog_len, load_err, running} !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b i=%h rdy=%b len=%0d err=%b run=%b want all zero",
               inst_valid, inst_out, load_ready, prog_len, load_err, running);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_fetch(16'd0);
      total++;
      if ({inst_valid, inst_out, running} !== 11'd0) begin
        bad++;
        $display("FAIL idle_fetch%0d: got v=%b i=%h run=%b want 0 0 0", i, inst_valid, inst_out, running);
      end
    end
  endtask

  task automatic test_load14();
    start_load();
    total++;
    if ({load_ready, running, prog_len} !== {1'b1, 1'b0, 17'd0}) begin
      bad++;
      $display("FAIL load_enter: got rdy=%b run=%b len=%0d want 1 0 0", load_ready, running, prog_len);
    end
    do_beat(SETI_W, 1'b0);
    for (int k = 1; k <= 12; k++) do_beat({5'b00001, 4'(k)}, 1'b0);
    do_beat(FILL_W, 1'b1);
    total++;
    if ({running, load_ready, load_err, prog_len} !== {1'b1, 1'b0, 1'b0, 17'd14}) begin
      bad++;
      $display("FAIL load14_done: got run=%b rdy=%b err=%b len=%0d want 1 0 0 14",
               running, load_ready, load_err, prog_len);
    end
    do_fetch(16'd13);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, 9'b110100000}) begin
      bad++;
      $display("FAIL fetch_last_slot: got v=%b i=%b want 1 110100000", inst_valid, inst_out);
    end
    do_fetch(16'd0);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, 9'b001100000}) begin
      bad++;
      $display("FAIL fetch_pc0: got v=%b i=%b want 1 001100000", inst_valid, inst_out);
    end
    do_fetch(16'd5);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, 9'b000010101}) begin
      bad++;
      $display("FAIL fetch_pc5: got v=%b i=%b want 1 000010101", inst_valid, inst_out);
    end
    do_fetch(16'd14);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, FILL_W}) begin
      bad++;
      $display("FAIL fetch_pc14_fill: got v=%b i=%b want 1 %b", inst_valid, inst_out, FILL_W);
    end
    do_fetch(16'hFFFF);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, FILL_W}) begin
      bad++;
      $display("FAIL fetch_ffff_fill: got v=%b i=%b want 1 %b", inst_valid, inst_out, FILL_W);
    end
    do_fetch(16'h0040);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, FILL_W}) begin
      bad++;
      $display("FAIL fetch_alias_fill: got v=%b i=%b want 1 %b", inst_valid, inst_out, FILL_W);
    end
  endtask

  task automatic test_stall();
    do_fetch(16'd1);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, 9'b000010001}) begin
      bad++;
      $display("FAIL stall_pre: got v=%b i=%b want 1 000010001", inst_valid, inst_out);
    end
    stall    = 1'b1;
    fetch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 16'(i * 5);
      tick();
      total++;
      if ({inst_valid, inst_out} !== {1'b1, 9'b000010001}) begin
        bad++;
        $display("FAIL stall_hold%0d: got v=%b i=%b want 1 000010001", i, inst_valid, inst_out);
      end
    end
    stall    = 1'b0;
    fetch_en = 1'b0;
    tick();
    total++;
    if ({inst_valid, inst_out} !== 10'd0) begin
      bad++;
      $display("FAIL bubble: got v=%b i=%b want 0 0", inst_valid, inst_out);
    end
  endtask

  task automatic test_overflow();
    start_load();
    for (int i = 1; i <= 63; i++) do_beat(9'h100 + 9'(i), 1'b0);
    total++;
    if ({load_err, running, prog_len} !== {1'b0, 1'b0, 17'd0}) begin
      bad++;
      $display("FAIL ovf_beat63: got err=%b run=%b len=%0d want 0 0 0", load_err, running, prog_len);
    end
    do_beat(9'h140, 1'b0);
    total++;
    if ({load_err, running, load_ready, prog_len} !== {1'b1, 1'b1, 1'b0, 17'd64}) begin
      bad++;
      $display("FAIL ovf_beat64: got err=%b run=%b rdy=%b len=%0d want 1 1 0 64",
               load_err, running, load_ready, prog_len);
    end
    for (int i = 65; i <= 67; i++) do_beat(9'h100 + 9'(i), 1'b0);
    total++;
    if ({load_err, prog_len} !== {1'b1, 17'd64}) begin
      bad++;
      $display("FAIL ovf_extra: got err=%b len=%0d want 1 64", load_err, prog_len);
    end
    do_fetch(16'd63);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, 9'h140}) begin
      bad++;
      $display("FAIL ovf_slot63: got v=%b i=%h want 1 140", inst_valid, inst_out);
    end
    do_fetch(16'd0);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, 9'h101}) begin
      bad++;
      $display("FAIL ovf_slot0: got v=%b i=%h want 1 101", inst_valid, inst_out);
    end
    do_fetch(16'd64);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, FILL_W}) begin
      bad++;
      $display("FAIL ovf_pc64_fill: got v=%b i=%h want 1 %h", inst_valid, inst_out, FILL_W);
    end
  endtask

  task automatic test_restart_and_reset();
    start_load();
    do_beat(9'h0AA, 1'b0);
    load_start = 1'b1;
    do_beat(9'h0BB, 1'b0);
    load_start = 1'b0;
    total++;
    if ({load_ready, load_err, prog_len} !== {1'b1, 1'b0, 17'd0}) begin
      bad++;
      $display("FAIL restart_state: got rdy=%b err=%b len=%0d want 1 0 0", load_ready, load_err, prog_len);
    end
    do_beat(9'h0CC, 1'b0);
    do_beat(9'h0DD, 1'b1);
    total++;
    if ({running, prog_len} !== {1'b1, 17'd2}) begin
      bad++;
      $display("FAIL restart_len: got run=%b len=%0d want 1 2", running, prog_len);
    end
    do_fetch(16'd0);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, 9'h0CC}) begin
      bad++;
      $display("FAIL restart_pc0: got v=%b i=%h want 1 0cc", inst_valid, inst_out);
    end
    do_fetch(16'd2);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, FILL_W}) begin
      bad++;
      $display("FAIL restart_pc2_fill: got v=%b i=%h want 1 %h", inst_valid, inst_out, FILL_W);
    end
    start_load();
    do_beat(9'h011, 1'b0);
    do_beat(9'h022, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if ({load_ready, running, prog_len, load_err} !== 20'd0) begin
      bad++;
      $display("FAIL rst_midload: got rdy=%b run=%b len=%0d err=%b want 0 0 0 0",
               load_ready, running, prog_len, load_err);
    end
    tick();
    rst = 1'b0;
    do_fetch(16'd0);
    total++;
    if ({inst_valid, inst_out, running} !== 11'd0) begin
      bad++;
      $display("FAIL rst_fetch: got v=%b i=%h run=%b want 0 0 0", inst_valid, inst_out, running);
    end
  endtask

  task automatic test_back_to_back();
    start_load();
    do_beat(9'h031, 1'b0);
    do_beat(9'h032, 1'b1);
    do_fetch(16'd1);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, 9'h032}) begin
      bad++;
      $display("FAIL b2b_prefetch: got v=%b i=%h want 1 032", inst_valid, inst_out);
    end
    load_start = 1'b1;
    do_fetch(16'd0);
    load_start = 1'b0;
    total++;
    if ({running, inst_valid, inst_out, load_ready} !== {1'b0, 1'b0, 9'd0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_drop: got run=%b v=%b i=%h rdy=%b want 0 0 0 1",
               running, inst_valid, inst_out, load_ready);
    end
    do_beat(9'h055, 1'b1);
    total++;
    if ({running, prog_len} !== {1'b1, 17'd1}) begin
      bad++;
      $display("FAIL b2b_len: got run=%b len=%0d want 1 1", running, prog_len);
    end
    do_fetch(16'd0);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, 9'h055}) begin
      bad++;
      $display("FAIL b2b_pc0: got v=%b i=%h want 1 055", inst_valid, inst_out);
    end
    do_fetch(16'd1);
    total++;
    if ({inst_valid, inst_out} !== {1'b1, FILL_W}) begin
      bad++;
      $display("FAIL b2b_pc1_fill: got v=%b i=%h want 1 %h", inst_valid, inst_out, FILL_W);
    end
  endtask

  initial begin
    rst        = 1'b1;
    pc         = '0;
    fetch_en   = 1'b0;
    stall      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    test_reset();
    test_load14();
    test_stall();
    test_overflow();
    test_restart_and_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, run-time loadable instruction memory for the pipelined CPU's fetch stage; successor to the fixed-case instruction ROM. A program is streamed in through a valid/ready load port. The fetch port then returns one instruction per cycle with one-cycle registered latency, stall hold and bubble insertion. Any PC beyond the loaded program returns a configurable fill word, HALT by default, instead of a silent zero.

## Interface
- INST_W, 9, instruction width: 5-bit opcode plus 4-bit operand
- PC_W, 16, program-counter width
- DEPTH, 64, instruction slots; power of two, ≤ 2^PC_W
- FILL, {HALT,4'b0000} = 9'b110100000, word returned for out-of-range PC
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  PC_W  fetch address
- fetch_en  in  1  request a fetch this cycle
- stall  in  1  pipeline stall; holds fetch output
- inst_out  out  INST_W  fetched instruction (registered)
- inst_valid  out  1  inst_out holds a real fetch
- load_start  in  1  begin (re)programming
- load_valid  in  1  load beat valid
- load_data  in  INST_W  instruction word for current load slot
- load_last  in  1  marks final beat of program
- load_ready  out  1  block accepts a beat (combinational from state)
- prog_len  out  PC_W+1  number of loaded instructions
- load_err  out  1  sticky: program overflowed DEPTH
- running  out  1  state == RUN

## Operation
- States: IDLE (reset), LOAD, RUN.
- IDLE -> LOAD on load_start; RUN -> LOAD on load_start. LOAD -> LOAD on load_start restarts wptr at 0.
- In LOAD, load_ready = 1; otherwise 0.
- load_start has priority over a same-cycle beat; that beat is discarded.
- On entering LOAD: wptr <= 0, prog_len <= 0, load_err <= 0.
- Beat (load_valid & load_ready): mem[wptr] <= load_data; wptr++.
- Beat with load_last: prog_len <= wptr+1; go to RUN.
- Beat at wptr = DEPTH-1 without load_last: word written, prog_len <= DEPTH, load_err <= 1, go to RUN. Beats are never written past DEPTH-1.
- RUN fetch, priority order:
  - stall = 1: inst_out and inst_valid hold, regardless of fetch_en or pc.
  - fetch_en & !stall: inst_out <= (pc < prog_len) ? mem[pc] : FILL; inst_valid <= 1. The full PC_W pc is compared, with no truncation aliasing.
  - !fetch_en & !stall: inst_out <= 0 (NOP/add bubble); inst_valid <= 0.
- IDLE/LOAD: inst_out <= 0, inst_valid <= 0; fetch_en and stall are ignored.
- Memory contents are not reset. After rst, prog_len = 0, so no stale word is ever returned.

## Timing
- Fetch latency: 1 cycle, pc sampled at edge N and valid after edge N.
- Load throughput: 1 beat per cycle.
- Fetch is available the cycle after the load_last beat. A fetch of the last-written slot on that first RUN cycle returns the new data.
- Reset values: inst_out = 0, inst_valid = 0, load_ready = 0, prog_len = 0, load_err = 0, running = 0, state IDLE, wptr = 0.
- rst mid-LOAD aborts the load; the program must be fully reloaded.
- load_start in RUN drops running and inst_valid on the next edge.

## Structure
- Shared package `cpu_isa_pkg`:
  - 5-bit opcode constants (add … halt)
  - HALT_WORD, NOP_WORD
  - imem_state_t enum {IDLE, LOAD, RUN}
- Sub-module `imem_array`: DEPTH×INST_W storage with synchronous write and asynchronous read. The top block owns the FSM, the pointers and the output register.

## Test plan
- Reset, then fetch_en=1, pc=0 for 3 cycles -> inst_valid=0, inst_out=0, running=0.
- Load 14 words with seti=9'b001100000 at slot 0 and halt=9'b110100000 at slot 13, last on beat 14. Then fetch pc=0 -> 9'b001100000 one cycle later, pc=13 -> 9'b110100000, pc=14 -> FILL, pc=16'hFFFF -> FILL, with prog_len=14.
- RUN, fetch pc=1, then stall=1 for 3 cycles while pc changes -> inst_out is held at mem[1] and inst_valid=1. stall=0 with fetch_en=0 -> inst_valid=0, inst_out=0.
- Stream DEPTH+3 beats with no load_last -> load_err=1 and prog_len=64 after beat 64. Later beats are ignored since load_ready=0, and mem[63] holds beat 64's data.
- Assert load_start together with a valid beat mid-load, then load 2 words -> the first beat is discarded and prog_len=2. Assert rst mid-load -> state IDLE and prog_len=0.
- Assert load_start while in RUN with fetches in flight -> running=0 and inst_valid=0 on the next edge. Reload 1 word -> fetch pc=0 returns it and pc=1 returns FILL.
